sal_ar_ctrl: RTL and testbench

AXI read-address (AR) front end that sits directly upstream of the read-control stage.
- Accepts AR beats and buffers them in a small queue.
- Decodes each address into bank/row/column and presents one read request at a time to the scheduler.
- Throttles requests with an outstanding-burst credit counter, so the downstream RID queue (16 entries) and read-data queue (8 beats) can never overflow.
- Credits return when the R channel completes a burst (last-beat handshake).

---
 rtl/sal_ar_ctrl_pkg.sv | 39 +++
 rtl/sal_ar_ctrl_fifo.sv | 50 +++++
 rtl/sal_ar_ctrl.sv | 142 ++++++++++++++
 tb/tb_sal_ar_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_ar_ctrl_pkg.sv
// Shared SAL DDR read-path types and parameters.
// AXI widths, address-field widths, AXI_RESP codes, AR beat and decoded-request structs.
package sal_ar_ctrl_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 4;
  localparam int COL_WIDTH      = 10;
  localparam int BA_WIDTH       = 2;
  localparam int ROW_WIDTH      = 14;

  // 16-byte data path: low address bits select a byte within a beat
  localparam int BYTE_OFS_WIDTH = 4;
  localparam int ADDR_DEC_MSB   =
    BYTE_OFS_WIDTH + COL_WIDTH + BA_WIDTH + ROW_WIDTH;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // the controller only issues 2-beat bursts (arlen = 1)
  localparam logic [AXI_LEN_WIDTH-1:0] BURST_LEN = 1;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
  } ar_beat_t;

  typedef struct packed {
    logic [BA_WIDTH-1:0]      ba;
    logic [ROW_WIDTH-1:0]     ra;
    logic [COL_WIDTH-1:0]     ca;
    logic [AXI_ID_WIDTH-1:0]  id;
    logic [AXI_LEN_WIDTH-1:0] len;
  } rd_req_t;

endpackage

// File: rtl/sal_ar_ctrl_fifo.sv
// Small synchronous FIFO with registered full/empty and show-ahead read data.
// Ports: push/wdata, pop/rdata, full, empty; overflow and underflow requests are dropped.
module sal_ar_ctrl_fifo #(
  parameter int W         = 8,
  parameter int DEPTH_LG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int CW    = DEPTH_LG2 + 1;

  logic [W-1:0]           mem [DEPTH];
  logic [DEPTH_LG2-1:0]   wptr;
  logic [DEPTH_LG2-1:0]   rptr;
  logic [CW-1:0]          cnt;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      if (do_push & ~do_pop) cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sal_ar_ctrl.sv
// AXI AR front end: queues AR beats, decodes bank/row/column, credit-throttles grants.
// Ports: AR channel in, req_* to scheduler, rd_gnt/r_done credits, outstanding, len_err.
// Optional SAL_AR_CTRL_STATS_EN adds stat_req_cnt and stat_stall_cnt.
module sal_ar_ctrl
  import sal_ar_ctrl_pkg::*;
#(
  parameter int  AR_DEPTH_LG2    = 2,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [AXI_ID_WIDTH-1:0]   arid,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [AXI_LEN_WIDTH-1:0]  arlen,
  output logic                      req_valid,
  output logic [BA_WIDTH-1:0]       req_ba,
  output logic [ROW_WIDTH-1:0]      req_ra,
  output logic [COL_WIDTH-1:0]      req_ca,
  output logic [AXI_ID_WIDTH-1:0]   req_id,
  output logic [AXI_LEN_WIDTH-1:0]  req_len,
  input  logic                      rd_gnt,
  input  logic                      r_done,
  output logic [OW-1:0]             outstanding,
  output logic                      len_err
`ifdef SAL_AR_CTRL_STATS_EN
  ,
  output logic [31:0]               stat_req_cnt,
  output logic [31:0]               stat_stall_cnt
`endif
);

  ar_beat_t      wr_beat;
  ar_beat_t      head;
  rd_req_t       req;
  logic          full;
  logic          empty;
  logic          push;
  logic          init_q;
  logic          len_err_q;
  logic [OW-1:0] out_q;
  logic          room;
  logic          gnt_ok;
  logic          done_ok;
  logic          unused_addr;

  // arready stays low until the first edge after reset release
  assign arready = init_q & ~full;
  assign push    = arvalid & arready;

  assign wr_beat.id   = arid;
  assign wr_beat.addr = araddr;
  assign wr_beat.len  = arlen;

  sal_ar_ctrl_fifo #(
    .W         ($bits(ar_beat_t)),
    .DEPTH_LG2 (AR_DEPTH_LG2)
  ) u_ar_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_beat),
    .pop   (gnt_ok),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign room      = (out_q < OW'(MAX_OUTSTANDING));
  assign req_valid = ~empty & room;
  assign gnt_ok    = rd_gnt & req_valid;
  assign done_ok   = r_done & (out_q != '0);

  always_comb begin
    req = '0;
    if (!empty) begin
      req.ca  = head.addr[BYTE_OFS_WIDTH +: COL_WIDTH];
      req.ba  = head.addr[BYTE_OFS_WIDTH+COL_WIDTH +: BA_WIDTH];
      req.ra  = head.addr[BYTE_OFS_WIDTH+COL_WIDTH+BA_WIDTH +: ROW_WIDTH];
      req.id  = head.id;
      req.len = head.len;
    end
  end

  assign unused_addr = ^{head.addr[BYTE_OFS_WIDTH-1:0],
                         head.addr[AXI_ADDR_WIDTH-1:ADDR_DEC_MSB]};

  assign req_ba  = req.ba;
  assign req_ra  = req.ra;
  assign req_ca  = req.ca;
  assign req_id  = req.id;
  assign req_len = req.len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q    <= 1'b0;
      out_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (gnt_ok & ~done_ok) out_q <= out_q + 1'b1;
      else if (done_ok & ~gnt_ok) out_q <= out_q - 1'b1;
      if (push && arlen != BURST_LEN) len_err_q <= 1'b1;
    end
  end

  assign outstanding = out_q;
  assign len_err     = len_err_q;

`ifdef SAL_AR_CTRL_STATS_EN
  logic [31:0] req_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (gnt_ok) req_cnt_q <= req_cnt_q + 1'b1;
      if (~empty && out_q == OW'(MAX_OUTSTANDING))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stat_req_cnt   = req_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_gnt: assert (!(rd_gnt && !req_valid))
        else $warning("sal_ar_ctrl: rd_gnt without req_valid ignored");
      a_done: assert (!(r_done && out_q == '0))
        else $warning("sal_ar_ctrl: r_done with nothing outstanding ignored");
    end
  end
`endif

endmodule

// File: tb/tb_sal_ar_ctrl.sv
// Testbench for sal_ar_ctrl: directed table, corner sequences, random vs queue model.
// Ports of the DUT are all driven/observed here; default build (no stats).
module tb_sal_ar_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic        rd_gnt = 1'b0;
  logic        r_done = 1'b0;
  logic        arready;
  logic        req_valid;
  logic [1:0]  req_ba;
  logic [13:0] req_ra;
  logic [9:0]  req_ca;
  logic [3:0]  req_id;
  logic [3:0]  req_len;
  logic [2:0]  outstanding;
  logic        len_err;

  always #5 clk = ~clk;

  sal_ar_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arvalid     (arvalid),
    .arready     (arready),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .req_valid   (req_valid),
    .req_ba      (req_ba),
    .req_ra      (req_ra),
    .req_ca      (req_ca),
    .req_id      (req_id),
    .req_len     (req_len),
    .rd_gnt      (rd_gnt),
    .r_done      (r_done),
    .outstanding (outstanding),
    .len_err     (len_err)
  );

  localparam int QD   = 4;
  localparam int MAXO = 4;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: queue of accepted ARs, burst credit count
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  ar_t mq[$];
  int  m_out;
  bit  m_init;
  bit  m_lerr;
  bit  dut_push;
  bit  dut_gnt;

  function automatic void m_reset();
    mq.delete();
    m_out  = 0;
    m_init = 0;
    m_lerr = 0;
  endfunction

  function automatic bit m_ready();
    return m_init && mq.size() < QD;
  endfunction

  function automatic bit m_rv();
    return mq.size() > 0 && m_out < MAXO;
  endfunction

  // drive one cycle's inputs, check against model, advance model
  task automatic step(input bit av, input logic [3:0] id,
                      input logic [31:0] a, input logic [3:0] l,
                      input bit g, input bit d);
    bit  rdy;
    bit  rv;
    bit  pu;
    bit  po;
    bit  dn;
    ar_t e;
    arvalid = av;
    arid    = id;
    araddr  = a;
    arlen   = l;
    rd_gnt  = g;
    r_done  = d;
    #1;
    rdy = m_ready();
    rv  = m_rv();
    chk("arready", arready, rdy);
    chk("req_valid", req_valid, rv);
    chk("outstanding", outstanding, m_out);
    chk("len_err", len_err, m_lerr);
    if (rv) begin
      chk("req_ca", req_ca, (mq[0].addr >> 4) % 1024);
      chk("req_ba", req_ba, (mq[0].addr >> 14) % 4);
      chk("req_ra", req_ra, (mq[0].addr >> 16) % 16384);
      chk("req_id", req_id, mq[0].id);
      chk("req_len", req_len, mq[0].len);
    end
    dut_push = av && arready;
    dut_gnt  = g && req_valid;
    pu = av && rdy;
    po = g && rv;
    dn = d && m_out > 0;
    e.id = id;
    e.addr = a;
    e.len = l;
    if (po) void'(mq.pop_front());
    if (pu) mq.push_back(e);
    if (pu && l != 4'd1) m_lerr = 1;
    if (po && !dn) m_out++;
    else if (dn && !po) m_out--;
    m_init = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit av, input logic [3:0] id,
                     input logic [31:0] a, input logic [3:0] l,
                     input bit g, input bit d);
    step(av, id, a, l, g, d);
    tick();
  endtask

  task automatic idle();
    cyc(0, '0, '0, '0, 0, 0);
  endtask

  // assert reset between edges; everything must clear at once
  task automatic do_reset();
    #2;
    rst_n   = 1'b0;
    arvalid = 1'b0;
    rd_gnt  = 1'b0;
    r_done  = 1'b0;
    #1;
    chk("rst arready", arready, 0);
    chk("rst req_valid", req_valid, 0);
    chk("rst outstanding", outstanding, 0);
    chk("rst len_err", len_err, 0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          av;
    logic [3:0]  id;
    logic [31:0] a;
    logic [3:0]  l;
    bit          g;
    bit          d;
    bit          rdy;
    bit          rv;
    int          out;
    bit          cr;
    logic [9:0]  ca;
    logic [1:0]  ba;
    logic [13:0] ra;
    logic [3:0]  rid;
    logic [3:0]  rlen;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(bit av, logic [3:0] id, logic [31:0] a,
                              bit g, bit d, bit rdy, bit rv, int out,
                              bit cr, logic [9:0] ca, logic [1:0] ba,
                              logic [13:0] ra, logic [3:0] rid);
    vec_t v;
    v.av = av; v.id = id; v.a = a; v.l = 4'd1;
    v.g = g; v.d = d; v.rdy = rdy; v.rv = rv; v.out = out;
    v.cr = cr; v.ca = ca; v.ba = ba; v.ra = ra;
    v.rid = rid; v.rlen = 4'd1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int grants;
    int acc;

    tbl[0] = mk(1, 3, 32'h0001_2340, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 3, 32'h0001_2340, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 10'h234, 0, 14'h1, 3);
    tbl[3] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, 5, 32'h3FFF_FFF0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 10'h3FF, 3, 14'h3FFF, 5);
    tbl[6] = mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 10'h3FF, 3, 14'h3FFF, 5);
    tbl[7] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[8] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[9] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    m_reset();
    #1;
    chk("init arready", arready, 0);
    chk("init req_valid", req_valid, 0);
    chk("init outstanding", outstanding, 0);
    chk("init len_err", len_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].av, tbl[i].id, tbl[i].a, tbl[i].l, tbl[i].g, tbl[i].d);
      chk($sformatf("t%0d arready", i), arready, tbl[i].rdy);
      chk($sformatf("t%0d req_valid", i), req_valid, tbl[i].rv);
      chk($sformatf("t%0d outstanding", i), outstanding, tbl[i].out);
      if (tbl[i].cr) begin
        chk($sformatf("t%0d ca", i), req_ca, tbl[i].ca);
        chk($sformatf("t%0d ba", i), req_ba, tbl[i].ba);
        chk($sformatf("t%0d ra", i), req_ra, tbl[i].ra);
        chk($sformatf("t%0d id", i), req_id, tbl[i].rid);
        chk($sformatf("t%0d len", i), req_len, tbl[i].rlen);
      end
      tick();
    end

    // credit limit: 6 ARs, grant held, no r_done
    do_reset();
    pushed = 0;
    grants = 0;
    for (int c = 0; c < 16; c++) begin
      step(pushed < 6, 4'(c), $urandom, 4'd1, 1, 0);
      if (dut_push) pushed++;
      if (dut_gnt) grants++;
      tick();
    end
    chk("lim pushed", pushed, 6);
    chk("lim grants", grants, 4);
    chk("lim req_valid", req_valid, 0);
    chk("lim outstanding", outstanding, 4);
    cyc(0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, 0, 0);
    chk("lim rv after done", req_valid, 1);
    chk("lim out after done", outstanding, 3);
    tick();

    // full queue: 5 ARs with no grant
    do_reset();
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 4'(c), $urandom, 4'd1, 0, 0);
      if (dut_push) acc++;
      tick();
    end
    chk("full accepted", acc, 4);
    chk("full arready", arready, 0);
    step(1, 4'd7, 32'h0000_1000, 4'd1, 1, 0);
    chk("full no push on pop", dut_push, 0);
    tick();
    step(1, 4'd7, 32'h0000_1000, 4'd1, 0, 0);
    chk("full arready after pop", arready, 1);
    if (dut_push) acc++;
    tick();
    chk("full accepted 5", acc, 5);

    // simultaneous grant and credit return at outstanding=2
    cyc(0, '0, '0, '0, 1, 0);
    chk("sim out before", outstanding, 2);
    cyc(0, '0, '0, '0, 1, 1);
    chk("sim out after", outstanding, 2);

    // length error is sticky and the request passes through
    do_reset();
    idle();
    step(1, 4'd9, 32'h0055_AA30, 4'd3, 0, 0);
    chk("len push", dut_push, 1);
    tick();
    step(0, '0, '0, '0, 0, 0);
    chk("len_err set", len_err, 1);
    chk("len fwd", req_len, 3);
    tick();
    cyc(0, '0, '0, '0, 1, 0);
    cyc(1, 4'd2, 32'h0000_0040, 4'd1, 0, 0);
    idle();
    chk("len_err sticky", len_err, 1);
    chk("len mid-burst out", outstanding, 1);
    do_reset();

    // spurious grant and spurious credit return
    idle();
    cyc(0, '0, '0, '0, 1, 0);
    cyc(0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, 0, 0);
    chk("spur outstanding", outstanding, 0);
    chk("spur req_valid", req_valid, 0);
    chk("spur arready", arready, 1);
    tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit g;
      bit d;
      g = m_rv() && ($urandom_range(0, 2) != 0);
      d = (m_out > 0) && ($urandom_range(0, 2) == 0);
      cyc(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
          ($urandom_range(0, 3) == 0) ? 4'd3 : 4'd1, g, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
